// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM state encodings and frame lengths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  localparam int UART_FRAME_BITS_8N1 = 10;
  localparam int UART_FRAME_BITS_8E1 = 11;

  // Even parity bit: makes the total number of ones (data + parity) even.
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter: circular buffer with stored count.
// Latency: a push is visible in count/empty one cycle later; head is read combinationally.
// Backpressure: registered full gates pushes (a same-cycle pop does not free a slot).
// Ports: clk, reset (sync, active-low), push/push_data in, pop in, head out,
//        count/full/empty out, empty_next (empty after this edge) out.
module uart_tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     empty_next
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_next;
  logic          push_ok;
  logic          pop_ok;

  assign push_ok    = push && !full;
  assign pop_ok     = pop && !empty;
  assign empty      = (count == '0);
  assign head       = mem[rd_ptr];
  assign empty_next = (count_next == '0);

  always_comb begin
    count_next = count;
    if (push_ok && !pop_ok) begin
      count_next = count + 1'b1;
    end else if (!push_ok && pop_ok) begin
      count_next = count - 1'b1;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == CW'(DEPTH));
    end
  end

  // Storage needs no reset; stale entries are never read while empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_fifo_transmitter.sv
// Buffered UART transmitter: queues bytes in a FIFO and sends them 8N1 (8E1 with UART_TX_PARITY_EN).
// Latency: tx_o falls one cycle after a push into an empty, idle transmitter; frames run back-to-back.
// Backpressure: pushes are dropped while full is high; full is registered.
// Ports: clk, reset (sync, active-low), data/send push interface, full, count (bytes queued,
//        excluding the one on the line), busy, tx_o (serial line, idles high).
// Build option: define UART_TX_PARITY_EN to add an even parity bit before STOP.
module uart_fifo_transmitter #(
  parameter int CLKS_PER_BIT = 2292,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    data,
  input  logic                          send,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          busy,
  output logic                          tx_o
);

  import uart_pkg::*;

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  tx_state_t     state;
  logic [BW-1:0] baud;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic [7:0]    head;
  logic          empty;
  logic          empty_next;
  logic          baud_end;
  logic          frame_slot;
  logic          pop;
`ifdef UART_TX_PARITY_EN
  logic          parity_bit;
`endif

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (send),
    .push_data  (data),
    .pop        (pop),
    .head       (head),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .empty_next (empty_next)
  );

  assign baud_end = (baud == BW'(CLKS_PER_BIT - 1));
  // A new frame may start from IDLE or on the edge that ends STOP (no idle gap).
  assign frame_slot = (state == ST_IDLE) || (state == ST_STOP && baud_end);
  assign pop        = frame_slot && !empty;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= ST_IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx_o    <= 1'b1;
      busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      // busy reflects the state/count after this edge, so it rises with the push.
      busy <= !(frame_slot && empty) || !empty_next;

      // tx_o is always set to the level of the state being entered.
      case (state)
        ST_IDLE: begin
          baud <= '0;
          tx_o <= 1'b1;
          if (pop) begin
            shift <= head;
`ifdef UART_TX_PARITY_EN
            parity_bit <= even_parity(head);
`endif
            state <= ST_START;
            tx_o  <= 1'b0;
          end
        end
        ST_START: begin
          if (baud_end) begin
            baud    <= '0;
            bit_idx <= '0;
            state   <= ST_DATA;
            tx_o    <= shift[0];
          end else begin
            baud <= baud + 1'b1;
          end
        end
        ST_DATA: begin
          if (baud_end) begin
            baud    <= '0;
            shift   <= shift >> 1;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= ST_PARITY;
              tx_o  <= parity_bit;
`else
              state <= ST_STOP;
              tx_o  <= 1'b1;
`endif
            end else begin
              tx_o <= shift[1];
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (baud_end) begin
            baud  <= '0;
            state <= ST_STOP;
            tx_o  <= 1'b1;
          end else begin
            baud <= baud + 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (baud_end) begin
            baud <= '0;
            if (pop) begin
              shift <= head;
`ifdef UART_TX_PARITY_EN
              parity_bit <= even_parity(head);
`endif
              state <= ST_START;
              tx_o  <= 1'b0;
            end else begin
              state <= ST_IDLE;
              tx_o  <= 1'b1;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          baud  <= '0;
          tx_o  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_fifo_transmitter.sv
// Self-checking bench for uart_fifo_transmitter with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Reference: a byte queue plus a per-cycle queue of expected line levels.
// Outputs are sampled 1 time unit after each rising edge.
module tb_uart_fifo_transmitter;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       send = 1'b0;
  logic [7:0] data = 8'h00;
  logic       full;
  logic       busy;
  logic       tx_o;
  logic [2:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] byte_q [$];
  bit         line_q [$];

  always #5 clk = ~clk;

  uart_fifo_transmitter #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .data  (data),
    .send  (send),
    .full  (full),
    .count (count),
    .busy  (busy),
    .tx_o  (tx_o)
  );

  // Expected {tx_o, busy, full, count} after the most recent edge.
  function automatic logic [5:0] model_vec();
    logic [5:0] v;
    v[5]   = (line_q.size() > 0) ? logic'(line_q[0]) : 1'b1;
    v[4]   = (line_q.size() > 0) || (byte_q.size() > 0);
    v[3]   = (byte_q.size() == DEPTH);
    v[2:0] = 3'(byte_q.size());
    return v;
  endfunction

  // Advance one clock and update the reference with the inputs seen at that edge.
  task automatic tick();
    bit         accept;
    logic [7:0] b;
    accept = send && (byte_q.size() < DEPTH);
    @(posedge clk);
    if (!reset) begin
      byte_q.delete();
      line_q.delete();
    end else begin
      if (line_q.size() > 0) void'(line_q.pop_front());
      if (line_q.size() == 0 && byte_q.size() > 0) begin
        b = byte_q.pop_front();
        repeat (CPB) line_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) repeat (CPB) line_q.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
        repeat (CPB) line_q.push_back(^b);
`endif
        repeat (CPB) line_q.push_back(1'b1);
      end
      if (accept) byte_q.push_back(data);
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    send  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({tx_o, busy, full, count} !== 6'b1_0_0_000) begin
        n_fail++;
        $display("FAIL reset cycle %0d: got %b required %b", i, {tx_o, busy, full, count}, 6'b100000);
      end
    end
    reset = 1'b1;
  endtask

  task automatic test_single_byte();
`ifdef UART_TX_PARITY_EN
    bit exp_bits [$] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 1};
`else
    bit exp_bits [$] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
`endif
    data = 8'h55;
    send = 1'b1;
    tick();
    send = 1'b0;
    n_checks++;
    if ({tx_o, busy, count} !== 5'b1_1_001) begin
      n_fail++;
      $display("FAIL single_push: got %b required %b", {tx_o, busy, count}, 5'b11001);
    end
    for (int i = 0; i < exp_bits.size(); i++) begin
      for (int c = 0; c < CPB; c++) begin
        tick();
        n_checks++;
        if (tx_o !== exp_bits[i] || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL single_bit %0d.%0d: got tx=%b busy=%b required tx=%b busy=1",
                   i, c, tx_o, busy, exp_bits[i]);
        end
      end
    end
    tick();
    n_checks++;
    if (tx_o !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_end: got tx=%b busy=%b required tx=1 busy=0", tx_o, busy);
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    bit exp_bits [$] = '{0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1};
    data = 8'h07;
    send = 1'b1;
    tick();
    send = 1'b0;
    for (int i = 0; i < exp_bits.size(); i++) begin
      for (int c = 0; c < CPB; c++) begin
        tick();
        n_checks++;
        if (tx_o !== exp_bits[i]) begin
          n_fail++;
          $display("FAIL parity_bit %0d.%0d: got %b required %b", i, c, tx_o, exp_bits[i]);
        end
      end
    end
    tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL parity_end: busy got %b required 0", busy);
    end
  endtask
`endif

  task automatic test_burst();
    logic [7:0] bytes [5] = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81};
    for (int i = 0; i < 5; i++) begin
      data = bytes[i];
      send = 1'b1;
      tick();
      n_checks++;
      if ({tx_o, busy, full, count} !== model_vec()) begin
        n_fail++;
        $display("FAIL burst_push %0d: got %b required %b", i, {tx_o, busy, full, count}, model_vec());
      end
    end
    send = 1'b0;
    n_checks++;
    if (full !== 1'b1) begin
      n_fail++;
      $display("FAIL burst_full: got %b required 1", full);
    end
    for (int i = 0; i < 1500; i++) begin
      if (byte_q.size() == 0 && line_q.size() == 0) break;
      tick();
      n_checks++;
      if ({tx_o, busy, full, count} !== model_vec()) begin
        n_fail++;
        $display("FAIL burst_drain cycle %0d: got %b required %b", i, {tx_o, busy, full, count}, model_vec());
      end
    end
    n_checks++;
    if (busy !== 1'b0 || line_q.size() != 0) begin
      n_fail++;
      $display("FAIL burst_idle: busy got %b required 0 (model pending %0d)", busy, line_q.size());
    end
  endtask

  task automatic test_back_to_back_pop_push();
    data = 8'h12;
    send = 1'b1;
    tick();
    data = 8'h34;
    tick();
    send = 1'b0;
    n_checks++;
    if (count !== 3'd1 || tx_o !== 1'b0) begin
      n_fail++;
      $display("FAIL pushpop_count: got count=%0d tx=%b required count=1 tx=0", count, tx_o);
    end
    for (int i = 0; i < 200; i++) begin
      if (byte_q.size() == 0 && line_q.size() == 0) break;
      tick();
      n_checks++;
      if ({tx_o, busy, full, count} !== model_vec()) begin
        n_fail++;
        $display("FAIL pushpop_drain cycle %0d: got %b required %b", i, {tx_o, busy, full, count}, model_vec());
      end
    end
    n_checks++;
    if (busy !== 1'b0 || line_q.size() != 0) begin
      n_fail++;
      $display("FAIL pushpop_idle: busy got %b required 0", busy);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] bytes [3] = '{8'hF7, 8'h5A, 8'hC3};
    for (int i = 0; i < 3; i++) begin
      data = bytes[i];
      send = 1'b1;
      tick();
    end
    send = 1'b0;
    // 15 more edges put the line inside data bit 3 of the first byte.
    repeat (15) tick();
    n_checks++;
    if (count !== 3'd2 || tx_o !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_pre: got count=%0d tx=%b required count=2 tx=0", count, tx_o);
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    n_checks++;
    if ({tx_o, busy, full, count} !== 6'b1_0_0_000) begin
      n_fail++;
      $display("FAIL midreset_edge: got %b required %b", {tx_o, busy, full, count}, 6'b100000);
    end
    for (int i = 0; i < 60; i++) begin
      tick();
      n_checks++;
      if ({tx_o, busy, full, count} !== 6'b1_0_0_000) begin
        n_fail++;
        $display("FAIL midreset_quiet cycle %0d: got %b required %b", i, {tx_o, busy, full, count}, 6'b100000);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      send = ($urandom_range(0, 2) == 0);
      data = 8'($urandom);
      tick();
      n_checks++;
      if ({tx_o, busy, full, count} !== model_vec()) begin
        n_fail++;
        $display("FAIL random cycle %0d: got %b required %b", i, {tx_o, busy, full, count}, model_vec());
      end
    end
    send = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (byte_q.size() == 0 && line_q.size() == 0) break;
      tick();
      n_checks++;
      if ({tx_o, busy, full, count} !== model_vec()) begin
        n_fail++;
        $display("FAIL random_drain cycle %0d: got %b required %b", i, {tx_o, busy, full, count}, model_vec());
      end
    end
    n_checks++;
    if (busy !== 1'b0 || line_q.size() != 0) begin
      n_fail++;
      $display("FAIL random_idle: busy got %b required 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_burst();
    test_back_to_back_pop_push();
    test_reset_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_fifo_transmitter.md
# uart_fifo_transmitter

Buffered UART transmitter that carries bytes from FPGA logic to the PC: the FPGA-to-PC end of the serial link that `uart_receiver` terminates. It accepts bytes through a push handshake into an internal FIFO, then serializes each byte as 8N1 (optionally 8E1) on `tx_o` at a fixed bit period. It sits beside `uart_receiver` in the top-level designs. Logic can queue multi-byte replies without waiting on `busy`.

## Interface
- `CLKS_PER_BIT`, default 2292: clock cycles per serial bit (220052 Hz / 96 baud); minimum 2.
- `FIFO_DEPTH`, default 8: FIFO entries; power of two, minimum 2.
- `clk  in  1`: single clock; all state changes on its rising edge.
- `reset  in  1`: synchronous, active-low reset; sampled on the `clk` rising edge.
- `data  in  8`: byte to queue; sampled when `send` is high.
- `send  in  1`: push request; one byte is accepted per cycle while `send` is high and `full` is low.
- `full  out  1`: FIFO holds `FIFO_DEPTH` bytes.
- `count  out  $clog2(FIFO_DEPTH)+1`: number of bytes queued, excluding the byte being shifted.
- `busy  out  1`: high while a frame is on the line or the FIFO is non-empty.
- `tx_o  out  1`: serial line; idles high.

## Operation
- Reset, while `reset` is low at the edge:
  - FIFO cleared; `count`=0, `full`=0, `busy`=0, `tx_o`=1.
  - FSM forced to IDLE; baud counter and bit index cleared.
- Reset mid-frame aborts the frame. `tx_o` is 1 after that edge, and the queued bytes are discarded.
- FIFO behaviour:
  - Circular buffer with wrapping read and write pointers; `count` is stored, not derived from the pointers.
  - A push while `full` is ignored: data dropped, no state change.
  - A push and a pop in the same cycle leave `count` unchanged.
  - At `full`, a same-cycle pop does not enable the push. `full` is a registered output and is the only gate.
- FSM states: IDLE, START, DATA, PARITY (only when the macro is defined), STOP.
  - IDLE: `tx_o`=1. If the FIFO is non-empty, pop the head into the shift register and go to START.
  - START: `tx_o`=0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
  - DATA: `tx_o`=shift[0] for `CLKS_PER_BIT` cycles, then shift right and increment the index. After index 7, go to PARITY or STOP.
  - PARITY: `tx_o`=even parity of the byte (XOR of all 8 bits) for `CLKS_PER_BIT` cycles, then go to STOP.
  - STOP: `tx_o`=1 for `CLKS_PER_BIT` cycles. Then, if the FIFO is non-empty, pop and go straight to START; otherwise go to IDLE.
- Bits go LSB first. `tx_o` is driven from a register, so there are no glitches.
- `busy` = (state != IDLE) | (`count` != 0), registered.

## Timing
- Baud counter counts 0 to `CLKS_PER_BIT`-1. It wraps to 0 on every state transition, so every bit lasts exactly `CLKS_PER_BIT` cycles.
- First byte, with the FIFO empty and the FSM in IDLE:
  - Push at edge N: `count`=1 and `busy`=1 after N.
  - Pop at edge N+1: `tx_o` falls after N+1 and `count` returns to 0.
- Frame length is 10×`CLKS_PER_BIT` cycles, or 11× with parity.
- Back-to-back frames have no idle gap: the START of frame k+1 begins on the edge that ends the STOP of frame k.
- `busy` falls on the edge that ends the last STOP.
- `full` updates on the edge after the push that fills the FIFO.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state is compiled in and each frame is 8E1, 11 bits.
- Without it: there is no PARITY state and no parity logic, and each frame is 8N1, 10 bits.

## Structure
- A shared package `uart_pkg` holds:
  - the FSM state encodings: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4;
  - the frame bit-count constants, `UART_FRAME_BITS_8N1`=10 and `UART_FRAME_BITS_8E1`=11.
- One sub-module, `uart_tx_fifo`, contains the pointers, `count`, `full`, `empty` and the storage.
- The top level holds the FSM, the baud counter and the shift register.

## Test plan
- Bench parameters: `CLKS_PER_BIT`=4, `FIFO_DEPTH`=4.
- Reset: hold `reset`=0 for 3 cycles → `tx_o`=1, `busy`=0, `count`=0, `full`=0.
- Single byte: push 0x55 → `tx_o` falls 1 cycle after the push, then 0,1,0,1,0,1,0,1,0,1 at 4 cycles per bit. `busy` falls after 40 cycles of frame.
- Burst: push 0xA5, 0x3C, 0xFF, 0x00, 0x81 on consecutive cycles.
  - `full` is high after the 5th push; 0x81 is dropped if the FIFO is full at that edge.
  - The accepted bytes are sent back-to-back with no idle between STOP and START.
- Simultaneous push and pop: push at the exact edge the FSM pops from IDLE → `count` stays 1 and both bytes are sent in order.
- Reset mid-frame: assert `reset` during DATA bit 3 with 2 bytes queued → `tx_o`=1 after the edge, `count`=0, `busy`=0, and no further frames.
- `UART_TX_PARITY_EN` build: push 0x07 → the 11-bit frame 0,1,1,1,0,0,0,0,0,1,1 is observed, with the parity bit = 1.
